// File: rtl/regbank_wr_arb.sv
// rtl/regbank_wr_arb.sv - round-robin write-port arbiter with bounded burst locking
module regbank_wr_arb #(
   parameter int NUM_REQ   = 3,
   parameter int SEL_W     = 6,
   parameter int DATA_W    = 64,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      regbank_we,
   output logic [SEL_W-1:0]          regbank_sel,
   output logic [DATA_W-1:0]         regbank_valout,
   output logic [1:0]                grant_id
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [1:0]       owner_q, owner_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

   logic              we_q;
   logic [SEL_W-1:0]  sel_q;
   logic [DATA_W-1:0] val_q;
   logic [1:0]        gid_q;

   logic              gnt_vld;
   logic [1:0]        gnt_idx;
   logic [SEL_W-1:0]  sel_mux;
   logic [DATA_W-1:0] data_mux;
   logic [2:0]        scan_sum;
   logic [1:0]        scan_idx;
   logic [CNT_W-1:0]  cnt_inc;

   // Index of the requester after i, wrapping at NUM_REQ.
   function automatic logic [1:0] wrap_inc(input logic [1:0] i);
      if (i == 2'(NUM_REQ - 1)) begin
         return 2'd0;
      end
      return i + 2'd1;
   endfunction

   // Grant selection plus next-state for pointer, lock owner and burst count.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      gnt_vld     = 1'b0;
      gnt_idx     = 2'd0;
      scan_sum    = 3'd0;
      scan_idx    = 2'd0;
      cnt_inc     = burst_cnt_q + CNT_W'(1);

      if (state_q == ST_OPEN) begin
         // Search starting at rr_ptr; first valid requester wins.
         for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + 3'(k);
            if (scan_sum >= 3'(NUM_REQ)) begin
               scan_sum = scan_sum - 3'(NUM_REQ);
            end
            scan_idx = scan_sum[1:0];
            if (!gnt_vld && req_valid[scan_idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = scan_idx;
            end
         end
         if (gnt_vld) begin
            if (req_lock[gnt_idx] && (MAX_BURST > 1)) begin
               state_d     = ST_LOCKED;
               owner_d     = gnt_idx;
               burst_cnt_d = CNT_W'(1);
            end else begin
               rr_ptr_d = wrap_inc(gnt_idx);
            end
         end
      end else begin
         // Only the owner may proceed; a missing beat ends the burst with a bubble.
         gnt_idx = owner_q;
         if (req_valid[owner_q]) begin
            gnt_vld = 1'b1;
            if (!req_lock[owner_q] || (cnt_inc == CNT_W'(MAX_BURST))) begin
               state_d     = ST_OPEN;
               rr_ptr_d    = wrap_inc(owner_q);
               burst_cnt_d = '0;
            end else begin
               burst_cnt_d = cnt_inc;
            end
         end else begin
            state_d     = ST_OPEN;
            rr_ptr_d    = wrap_inc(owner_q);
            burst_cnt_d = '0;
         end
      end

      if (!rst_n) begin
         gnt_vld = 1'b0;
      end
   end

   // One-hot ready and the granted requester's select/data.
   always_comb begin
      req_ready = '0;
      sel_mux   = '0;
      data_mux  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == 2'(i)) begin
            req_ready[i] = gnt_vld;
            sel_mux      = req_sel[i*SEL_W +: SEL_W];
            data_mux     = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Arbitration state registers; reset drops any lock in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_OPEN;
         rr_ptr_q    <= 2'd0;
         owner_q     <= 2'd0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Registered write port; select/value/id hold when no beat transfers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q  <= 1'b0;
         sel_q <= '0;
         val_q <= '0;
         gid_q <= 2'd0;
      end else begin
         we_q <= gnt_vld;
         if (gnt_vld) begin
            sel_q <= sel_mux;
            val_q <= data_mux;
            gid_q <= gnt_idx;
         end
      end
   end

   assign regbank_we     = we_q;
   assign regbank_sel    = sel_q;
   assign regbank_valout = val_q;
   assign grant_id       = gid_q;

endmodule

// File: tb/tb_regbank_wr_arb.sv
// tb/tb_regbank_wr_arb.sv - randomized and directed bench for regbank_wr_arb
module tb_regbank_wr_arb;

   localparam int N  = 3;
   localparam int SW = 6;
   localparam int DW = 64;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_lock;
   logic [N*SW-1:0] req_sel;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            regbank_we;
   logic [SW-1:0]   regbank_sel;
   logic [DW-1:0]   regbank_valout;
   logic [1:0]      grant_id;

   regbank_wr_arb #(.NUM_REQ(N), .SEL_W(SW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
      .req_sel(req_sel), .req_data(req_data), .req_ready(req_ready),
      .regbank_we(regbank_we), .regbank_sel(regbank_sel),
      .regbank_valout(regbank_valout), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: whole-integer view of the arbitration rules
   int          m_rr = 0, m_owner = 0, m_cnt = 0;
   bit          m_locked = 0;
   logic        e_we = 0;
   logic [SW-1:0] e_sel = '0;
   logic [DW-1:0] e_data = '0;
   logic [1:0]  e_gid = '0;

   int           exp_g;
   logic [N-1:0] exp_ready, obs_ready;
   logic [1+SW+DW+1:0] obs_out, exp_out;

   function automatic int model_grant();
      if (!rst_n) return -1;
      if (m_locked) return req_valid[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++)
         if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
      return -1;
   endfunction

   task automatic model_update(input int g);
      if (!rst_n) begin
         m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
         e_we = 0; e_sel = '0; e_data = '0; e_gid = '0;
         return;
      end
      e_we = (g >= 0);
      if (g >= 0) begin
         e_sel  = req_sel[g*SW +: SW];
         e_data = req_data[g*DW +: DW];
         e_gid  = 2'(g);
      end
      if (m_locked) begin
         if (g >= 0) m_cnt++;
         if (g < 0 || !req_lock[m_owner] || m_cnt == MB) begin
            m_locked = 0; m_rr = (m_owner + 1) % N; m_cnt = 0;
         end
      end else if (g >= 0) begin
         if (req_lock[g] && MB > 1) begin
            m_locked = 1; m_owner = g; m_cnt = 1;
         end else begin
            m_rr = (g + 1) % N;
         end
      end
   endtask

   // One clock: sample ready mid-cycle, then the registered outputs after the edge.
   task automatic cycle();
      #2;
      obs_ready = req_ready;
      exp_g     = model_grant();
      exp_ready = (exp_g >= 0) ? N'(1 << exp_g) : '0;
      @(posedge clk);
      #1;
      model_update(exp_g);
      obs_out = {regbank_we, regbank_sel, regbank_valout, grant_id};
      exp_out = {e_we, e_sel, e_data, e_gid};
   endtask

   task automatic set_all(input logic [N-1:0] v, input logic [N-1:0] l);
      req_valid = v;
      req_lock  = l;
      for (int i = 0; i < N; i++) begin
         req_sel[i*SW +: SW]  = SW'($urandom);
         req_data[i*DW +: DW] = {$urandom, $urandom};
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         set_all('1, '0);
         cycle();
         n_checks++;
         if (obs_ready !== '0) begin
            n_fail++; $display("FAIL reset_ready cycle %0d: got %b want 000", c, obs_ready);
         end
         n_checks++;
         if (regbank_we !== 1'b0 || regbank_sel !== '0 || regbank_valout !== '0 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b sel=%0d val=%h gid=%0d want all zero",
                     regbank_we, regbank_sel, regbank_valout, grant_id);
         end
      end
   endtask

   task automatic test_single();
      rst_n = 1'b1;
      set_all(3'b010, 3'b000);
      req_sel[SW +: SW]  = 6'd5;
      req_data[DW +: DW] = 64'hDEAD_BEEF;
      cycle();
      n_checks++;
      if (obs_ready !== 3'b010) begin
         n_fail++; $display("FAIL single_ready: got %b want 010", obs_ready);
      end
      n_checks++;
      if (regbank_we !== 1'b1 || regbank_sel !== 6'd5 || regbank_valout !== 64'hDEAD_BEEF || grant_id !== 2'd1) begin
         n_fail++;
         $display("FAIL single_write: got we=%b sel=%0d val=%h gid=%0d want 1/5/deadbeef/1",
                  regbank_we, regbank_sel, regbank_valout, grant_id);
      end
      set_all(3'b000, 3'b000);
      cycle();
      n_checks++;
      if (regbank_we !== 1'b0 || regbank_sel !== 6'd5 || regbank_valout !== 64'hDEAD_BEEF || grant_id !== 2'd1) begin
         n_fail++;
         $display("FAIL single_hold: got we=%b sel=%0d val=%h gid=%0d want 0/5/deadbeef/1",
                  regbank_we, regbank_sel, regbank_valout, grant_id);
      end
   endtask

   // Runs a directed sequence; ready is checked against the table and the model.
   task automatic run_seq(input string name, input logic [N-1:0] v[], input logic [N-1:0] l[],
                          input int g[]);
      for (int c = 0; c < g.size(); c++) begin
         set_all(v[c], l[c]);
         cycle();
         n_checks++;
         if (obs_ready !== ((g[c] >= 0) ? N'(1 << g[c]) : N'(0))) begin
            n_fail++; $display("FAIL %s_ready cycle %0d: got %b want grant %0d", name, c, obs_ready, g[c]);
         end
         n_checks++;
         if (obs_ready !== exp_ready) begin
            n_fail++; $display("FAIL %s_model_ready cycle %0d: got %b want %b", name, c, obs_ready, exp_ready);
         end
         n_checks++;
         if (obs_out !== exp_out) begin
            n_fail++; $display("FAIL %s_outputs cycle %0d: got %h want %h", name, c, obs_out, exp_out);
         end
         n_checks++;
         if (regbank_we !== (g[c] >= 0) || (g[c] >= 0 && grant_id !== 2'(g[c]))) begin
            n_fail++; $display("FAIL %s_we_gid cycle %0d: got we=%b gid=%0d want grant %0d",
                               name, c, regbank_we, grant_id, g[c]);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_all('0, '0);
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      do_reset();
      run_seq("rr", '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111},
              '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000}, '{0, 1, 2, 0, 1});
   endtask

   task automatic test_burst();
      do_reset();
      run_seq("burst", '{3'b100, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111},
              '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100},
              '{2, 2, 2, 2, 0, 1, 2});
   endtask

   task automatic test_bubble();
      do_reset();
      run_seq("bubble", '{3'b111, 3'b111, 3'b110, 3'b110},
              '{3'b001, 3'b001, 3'b001, 3'b000}, '{0, 0, -1, 1});
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      run_seq("lockpre", '{3'b111, 3'b111, 3'b111}, '{3'b010, 3'b010, 3'b010}, '{0, 1, 1});
      rst_n = 1'b0;
      run_seq("lockrst", '{3'b111}, '{3'b010}, '{-1});
      rst_n = 1'b1;
      run_seq("lockpost", '{3'b111, 3'b111}, '{3'b000, 3'b000}, '{0, 1});
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         set_all(N'($urandom), N'($urandom));
         cycle();
         n_checks++;
         if (obs_ready !== exp_ready) begin
            n_fail++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, obs_ready, exp_ready);
         end
         n_checks++;
         if (obs_out !== exp_out) begin
            n_fail++; $display("FAIL rand_outputs cycle %0d: got %h want %h", c, obs_out, exp_out);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      req_sel   = '0;
      req_data  = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_burst();
      test_bubble();
      test_reset_mid_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
